// File: rtl/gpio_int_prio_ctrl.sv
// Fixed-priority GPIO interrupt controller: latches edge/level events, issues the lowest
// eligible index on INTR/INT_CODE, and runs the INTA_N handshake with an optional ack timeout.
module gpio_int_prio_ctrl #(
  parameter int unsigned N_SRC   = 32,
  parameter int unsigned CODE_W  = 7,
  parameter int unsigned TMO_W   = 16,
  parameter int unsigned TMO_CYC = 1000
) (
  input  logic              clk_50m,
  input  logic              rstn_50m,
  input  logic [N_SRC-1:0]  int_src,
  input  logic [N_SRC-1:0]  int_mask,
  input  logic [N_SRC-1:0]  int_edge,
  input  logic              INTA_N,
  output logic              INTR,
  output logic [CODE_W-1:0] INT_CODE,
  output logic [N_SRC-1:0]  int_pend,
  output logic              int_timeout
);

  localparam bit               TMO_EN  = (TMO_CYC != 0);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'((TMO_CYC == 0) ? 0 : TMO_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACKW
  } state_t;

  state_t              state_q, state_d;
  logic [N_SRC-1:0]    pend_q, pend_d;
  logic [N_SRC-1:0]    src_d1_q;
  logic                intr_q, intr_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                tmo_q, tmo_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic [N_SRC-1:0]    set_vec, clr_vec, elig;
  logic [CODE_W-1:0]   win_code;
  logic                ack_clr;

  always_ff @(posedge clk_50m or negedge rstn_50m) begin
    if (!rstn_50m) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      src_d1_q <= '0;
      intr_q   <= 1'b0;
      code_q   <= '0;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      src_d1_q <= int_src;
      intr_q   <= intr_d;
      code_q   <= code_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    intr_d   = intr_q;
    code_d   = code_q;
    tmo_d    = 1'b0;
    cnt_d    = cnt_q;
    ack_clr  = 1'b0;
    clr_vec  = '0;
    win_code = '0;

    set_vec = (int_src & ~src_d1_q & int_edge) | (int_src & ~int_edge);
    elig    = pend_q & ~int_mask;

    // Walk from the lowest-priority end so the lowest eligible index is left standing.
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (elig[i]) win_code = CODE_W'(i + 1);
    end

    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          intr_d  = 1'b1;
          code_d  = win_code;
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!INTA_N) begin
          ack_clr = 1'b1;
          intr_d  = 1'b0;
          code_d  = '0;
          state_d = ST_ACKW;
        end else if (TMO_EN && (cnt_q == TMO_LIM)) begin
          intr_d  = 1'b0;
          code_d  = '0;
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      ST_ACKW: begin
        if (INTA_N) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < int'(N_SRC); i++) begin
      clr_vec[i] = ack_clr && (code_q == CODE_W'(i + 1));
    end

    // A new event on the acknowledged bit survives the clear.
    pend_d = (pend_q & ~clr_vec) | set_vec;
  end

  assign INTR        = intr_q;
  assign INT_CODE    = code_q;
  assign int_pend    = pend_q;
  assign int_timeout = tmo_q;

endmodule

// File: tb/tb_gpio_int_prio_ctrl.sv
// Bench for gpio_int_prio_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_gpio_int_prio_ctrl;

  localparam int N   = 32;
  localparam int CW  = 7;
  localparam int TMO = 8;

  logic          clk_50m = 1'b0;
  logic          rstn_50m;
  logic [N-1:0]  int_src, int_mask, int_edge;
  logic          INTA_N;
  logic          INTR;
  logic [CW-1:0] INT_CODE;
  logic [N-1:0]  int_pend;
  logic          int_timeout;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending flags, previous source levels, issued code (0 = none),
  // handshake phase (0 idle, 1 requesting, 2 waiting for release) and cycles spent requesting.
  bit m_pend[N];
  bit m_prev[N];
  int m_code, m_phase, m_age;
  bit m_tmo;

  gpio_int_prio_ctrl #(
    .N_SRC(N), .CODE_W(CW), .TMO_W(16), .TMO_CYC(TMO)
  ) dut (
    .clk_50m(clk_50m), .rstn_50m(rstn_50m), .int_src(int_src), .int_mask(int_mask),
    .int_edge(int_edge), .INTA_N(INTA_N), .INTR(INTR), .INT_CODE(INT_CODE),
    .int_pend(int_pend), .int_timeout(int_timeout)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_prev[i] = 1'b0;
    end
    m_code = 0; m_phase = 0; m_age = 0; m_tmo = 1'b0;
  endtask

  function automatic logic [N-1:0] m_pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit m_any();
    for (int i = 0; i < N; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge();
    bit nxt[N];
    int win;
    if (!rstn_50m) begin
      model_reset();
      return;
    end
    nxt = m_pend;
    if (m_phase == 1 && !INTA_N) nxt[m_code-1] = 1'b0;
    for (int i = 0; i < N; i++)
      if (int_edge[i] ? (int_src[i] && !m_prev[i]) : int_src[i]) nxt[i] = 1'b1;
    win = -1;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && !int_mask[i]) begin win = i; break; end
    m_tmo = 1'b0;
    case (m_phase)
      0: if (win >= 0) begin m_code = win + 1; m_phase = 1; m_age = 0; end
      1: begin
        if (!INTA_N) begin m_code = 0; m_phase = 2; end
        else if (m_age + 1 == TMO) begin m_code = 0; m_tmo = 1'b1; m_phase = 0; end
        else m_age++;
      end
      default: if (INTA_N) m_phase = 0;
    endcase
    for (int i = 0; i < N; i++) m_prev[i] = int_src[i];
    m_pend = nxt;
  endtask

  // Advance one clock, update the model with the inputs seen at the edge, settle past it.
  task automatic tick();
    @(posedge clk_50m);
    model_edge();
    #1;
  endtask

  task automatic drain();
    int_src = '0; int_mask = '0; int_edge = '1;
    for (int c = 0; c < 300; c++) begin
      if (m_phase == 0 && !m_any()) break;
      INTA_N = (m_phase != 1);
      tick();
    end
    INTA_N = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset();
    rstn_50m = 1'b0; int_src = '0; int_mask = '0; int_edge = '1; INTA_N = 1'b1;
    model_reset();
    tick(); tick();
    n_vec++; if (INTR !== 1'b0) begin n_err++; $display("FAIL reset_intr got %b want 0", INTR); end
    n_vec++; if (INT_CODE !== '0) begin n_err++; $display("FAIL reset_code got %0d want 0", INT_CODE); end
    n_vec++; if (int_pend !== '0) begin n_err++; $display("FAIL reset_pend got %h want 0", int_pend); end
    n_vec++; if (int_timeout !== 1'b0) begin n_err++; $display("FAIL reset_tmo got %b want 0", int_timeout); end
    rstn_50m = 1'b1;
    tick();
  endtask

  task automatic test_single_edge();
    int_src = 32'h20;
    tick();
    n_vec++; if (INTR !== 1'b0 || int_pend !== 32'h20) begin
      n_err++; $display("FAIL single_latency got intr=%b pend=%h want intr=0 pend=00000020", INTR, int_pend); end
    tick();
    n_vec++; if (INTR !== 1'b1 || INT_CODE !== 7'd6) begin
      n_err++; $display("FAIL single_issue got intr=%b code=%0d want intr=1 code=6", INTR, INT_CODE); end
    int_src = '0; INTA_N = 1'b0;
    tick();
    n_vec++; if (INTR !== 1'b0 || INT_CODE !== '0 || int_pend !== '0) begin
      n_err++; $display("FAIL single_ack got intr=%b code=%0d pend=%h want 0/0/0", INTR, INT_CODE, int_pend); end
    INTA_N = 1'b1;
    tick(); tick();
  endtask

  task automatic test_two_sources();
    int_src = 32'h208;
    tick(); int_src = '0; tick();
    n_vec++; if (INTR !== 1'b1 || INT_CODE !== 7'd4) begin
      n_err++; $display("FAIL prio_first got intr=%b code=%0d want intr=1 code=4", INTR, INT_CODE); end
    INTA_N = 1'b0;
    tick();
    n_vec++; if (INTR !== 1'b0 || int_pend !== 32'h200) begin
      n_err++; $display("FAIL prio_ack got intr=%b pend=%h want intr=0 pend=00000200", INTR, int_pend); end
    INTA_N = 1'b1;
    tick();
    n_vec++; if (INTR !== 1'b0) begin n_err++; $display("FAIL prio_release got intr=%b want 0", INTR); end
    tick();
    n_vec++; if (INTR !== 1'b1 || INT_CODE !== 7'd10) begin
      n_err++; $display("FAIL prio_second got intr=%b code=%0d want intr=1 code=10", INTR, INT_CODE); end
    drain();
  endtask

  task automatic test_mask();
    int_mask = 32'h4; int_src = 32'h4;
    tick(); int_src = '0; tick(); tick();
    n_vec++; if (INTR !== 1'b0 || int_pend !== 32'h4) begin
      n_err++; $display("FAIL mask_hold got intr=%b pend=%h want intr=0 pend=00000004", INTR, int_pend); end
    int_mask = '0;
    tick();
    n_vec++; if (INTR !== 1'b1 || INT_CODE !== 7'd3) begin
      n_err++; $display("FAIL mask_release got intr=%b code=%0d want intr=1 code=3", INTR, INT_CODE); end
    drain();
  endtask

  task automatic test_level();
    int_edge = ~32'h80; int_src = 32'h80;
    tick(); tick();
    n_vec++; if (INTR !== 1'b1 || INT_CODE !== 7'd8) begin
      n_err++; $display("FAIL level_issue got intr=%b code=%0d want intr=1 code=8", INTR, INT_CODE); end
    INTA_N = 1'b0;
    tick();
    n_vec++; if (INTR !== 1'b0 || int_pend[7] !== 1'b1) begin
      n_err++; $display("FAIL level_ack got intr=%b pend7=%b want intr=0 pend7=1", INTR, int_pend[7]); end
    tick();
    n_vec++; if (INTR !== 1'b0) begin n_err++; $display("FAIL level_ackw got intr=%b want 0", INTR); end
    INTA_N = 1'b1;
    tick(); tick();
    n_vec++; if (INTR !== 1'b1 || INT_CODE !== 7'd8) begin
      n_err++; $display("FAIL level_reissue got intr=%b code=%0d want intr=1 code=8", INTR, INT_CODE); end
    int_src = '0; INTA_N = 1'b0;
    tick();
    n_vec++; if (int_pend !== '0) begin n_err++; $display("FAIL level_clear got pend=%h want 0", int_pend); end
    drain();
  endtask

  task automatic test_timeout();
    int_src = 32'h10;
    tick(); tick();
    n_vec++; if (INTR !== 1'b1 || INT_CODE !== 7'd5) begin
      n_err++; $display("FAIL tmo_issue got intr=%b code=%0d want intr=1 code=5", INTR, INT_CODE); end
    int_src = 32'h2;
    for (int c = 0; c < TMO - 1; c++) begin
      tick();
      n_vec++; if (INTR !== 1'b1 || INT_CODE !== 7'd5 || int_timeout !== 1'b0) begin
        n_err++; $display("FAIL tmo_hold cyc=%0d got intr=%b code=%0d tmo=%b want 1/5/0", c, INTR, INT_CODE, int_timeout); end
    end
    tick();
    n_vec++; if (INTR !== 1'b0 || int_timeout !== 1'b1 || int_pend !== 32'h12) begin
      n_err++; $display("FAIL tmo_fire got intr=%b tmo=%b pend=%h want 0/1/00000012", INTR, int_timeout, int_pend); end
    int_src = '0;
    tick();
    n_vec++; if (INTR !== 1'b1 || INT_CODE !== 7'd2 || int_timeout !== 1'b0) begin
      n_err++; $display("FAIL tmo_rearb got intr=%b code=%0d tmo=%b want 1/2/0", INTR, INT_CODE, int_timeout); end
    drain();
  endtask

  task automatic test_reset_mid_req();
    int_src = 32'h840;
    tick(); int_src = '0; tick();
    n_vec++; if (INTR !== 1'b1 || INT_CODE !== 7'd7) begin
      n_err++; $display("FAIL rst_pre got intr=%b code=%0d want intr=1 code=7", INTR, INT_CODE); end
    #2 rstn_50m = 1'b0;
    model_reset();
    #1;
    n_vec++; if (INTR !== 1'b0 || INT_CODE !== '0 || int_pend !== '0) begin
      n_err++; $display("FAIL rst_async got intr=%b code=%0d pend=%h want 0/0/0", INTR, INT_CODE, int_pend); end
    tick(); tick();
    rstn_50m = 1'b1;
    tick(); tick();
    n_vec++; if (INTR !== 1'b0 || int_pend !== '0) begin
      n_err++; $display("FAIL rst_after got intr=%b pend=%h want 0/0", INTR, int_pend); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        int_edge = $urandom;
        int_mask = $urandom & $urandom;
      end
      int_src = $urandom & $urandom & $urandom & $urandom;
      INTA_N  = ($urandom_range(3) != 0);
      tick();
      n_vec++; if (INTR !== (m_code != 0) || INT_CODE !== CW'(m_code)) begin
        n_err++; $display("FAIL rand_req cyc=%0d got intr=%b code=%0d want code=%0d", c, INTR, INT_CODE, m_code); end
      n_vec++; if (int_pend !== m_pend_vec()) begin
        n_err++; $display("FAIL rand_pend cyc=%0d got %h want %h", c, int_pend, m_pend_vec()); end
      n_vec++; if (int_timeout !== m_tmo) begin
        n_err++; $display("FAIL rand_tmo cyc=%0d got %b want %b", c, int_timeout, m_tmo); end
    end
    drain();
    n_vec++; if (INTR !== 1'b0 || int_pend !== '0) begin
      n_err++; $display("FAIL rand_drain got intr=%b pend=%h want 0/0", INTR, int_pend); end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_two_sources();
    test_mask();
    test_level();
    test_timeout();
    test_reset_mid_req();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
